// File: rtl/usb_rw_sequencer.sv
// usb_rw_sequencer
// Turns one host read/write request into two USB protocol transactions:
// an address OUT to ADDR_ENDP, then a data OUT (write) or data IN (read)
// to DATA_ENDP. Each phase is retried on protocol failure up to MAX_RETRY
// times before the request is cancelled. The request is latched on
// acceptance, so the host task may change its inputs while busy.
//
// Outputs are decoded from the registered state. The cancel strobe must
// coincide with the failing response cycle, so done/cancel in the wait
// states also depend on the bad/free inputs of that cycle.

module usb_rw_sequencer #(
  parameter logic [6:0] DEV_ADDR  = 7'd5,
  parameter logic [3:0] ADDR_ENDP = 4'd4,
  parameter logic [3:0] DATA_ENDP = 4'd8,
  parameter int         ADDR_W    = 16,
  parameter int         DATA_W    = 64,
  parameter int         MAX_RETRY = 3,
  parameter int         RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clk,
  input  logic               rst_L,
  input  logic               tran_ready,
  input  logic               read,
  input  logic [ADDR_W-1:0]  rw_addr,
  input  logic [DATA_W-1:0]  data_down_rw,
  input  logic               free,
  input  logic               bad,
  input  logic               recv_ready_pro,
  input  logic [DATA_W-1:0]  data_up_pro,
  output logic               send_in,
  output logic               input_ready,
  output logic [6:0]         addr,
  output logic [3:0]         endp,
  output logic [DATA_W-1:0]  data_down_pro,
  output logic [DATA_W-1:0]  data_up_rw,
  output logic               recv_ready,
  output logic               done,
  output logic               cancel,
  output logic               busy,
  output logic [RETRY_W-1:0] retries
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    A_ISSUE = 3'd1,
    A_WAIT  = 3'd2,
    D_ISSUE = 3'd3,
    D_WAIT  = 3'd4,
    FINISH  = 3'd5
  } state_t;

  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

  // Address payload: target address left-justified, low bits zero.
  function automatic logic [DATA_W-1:0] addr_payload(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] p;
    p = '0;
    p[DATA_W-1 -: ADDR_W] = a;
    return p;
  endfunction

  state_t              state_r, state_s;
  logic                read_r, read_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [DATA_W-1:0]   data_r, data_s;
  logic [DATA_W-1:0]   cap_r, cap_s;
  logic                cap_valid_r, cap_valid_s;
  logic [RETRY_W-1:0]  retries_r, retries_s;
  logic                data_fail_s;

  // State and request/capture registers; reset aborts without any strobe.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_r     <= IDLE;
      read_r      <= 1'b0;
      addr_r      <= '0;
      data_r      <= '0;
      cap_r       <= '0;
      cap_valid_r <= 1'b0;
      retries_r   <= '0;
    end else begin
      state_r     <= state_s;
      read_r      <= read_s;
      addr_r      <= addr_s;
      data_r      <= data_s;
      cap_r       <= cap_s;
      cap_valid_r <= cap_valid_s;
      retries_r   <= retries_s;
    end
  end

  // Next-state, register updates and output decode.
  always_comb begin
    state_s       = state_r;
    read_s        = read_r;
    addr_s        = addr_r;
    data_s        = data_r;
    cap_s         = cap_r;
    cap_valid_s   = cap_valid_r;
    retries_s     = retries_r;
    data_fail_s   = 1'b0;
    send_in       = 1'b0;
    input_ready   = 1'b0;
    addr          = 7'd0;
    endp          = 4'd0;
    data_down_pro = '0;
    data_up_rw    = '0;
    recv_ready    = 1'b0;
    done          = 1'b0;
    cancel        = 1'b0;

    case (state_r)
      IDLE: begin
        if (tran_ready) begin
          read_s    = read;
          addr_s    = rw_addr;
          data_s    = data_down_rw;
          retries_s = '0;
          state_s   = A_ISSUE;
        end else begin
          state_s = IDLE;
        end
      end

      A_ISSUE: begin
        input_ready   = 1'b1;
        addr          = DEV_ADDR;
        endp          = ADDR_ENDP;
        data_down_pro = addr_payload(addr_r);
        state_s       = A_WAIT;
      end

      A_WAIT: begin
        addr          = DEV_ADDR;
        endp          = ADDR_ENDP;
        data_down_pro = addr_payload(addr_r);
        // bad wins over a simultaneous free.
        if (bad) begin
          if (retries_r < RETRY_MAX) begin
            retries_s = retries_r + RETRY_ONE;
            state_s   = A_ISSUE;
          end else begin
            done    = 1'b1;
            cancel  = 1'b1;
            state_s = IDLE;
          end
        end else if (free) begin
          retries_s = '0;
          state_s   = D_ISSUE;
        end else begin
          state_s = A_WAIT;
        end
      end

      D_ISSUE: begin
        input_ready = 1'b1;
        addr        = DEV_ADDR;
        endp        = DATA_ENDP;
        send_in     = read_r;
        if (read_r) begin
          data_down_pro = '0;
        end else begin
          data_down_pro = data_r;
        end
        // Data seen in an earlier attempt must not satisfy this one.
        cap_valid_s = 1'b0;
        state_s     = D_WAIT;
      end

      D_WAIT: begin
        addr    = DEV_ADDR;
        endp    = DATA_ENDP;
        send_in = read_r;
        if (read_r) begin
          data_down_pro = '0;
        end else begin
          data_down_pro = data_r;
        end
        // Last IN payload of the attempt wins.
        if (read_r && recv_ready_pro) begin
          cap_s       = data_up_pro;
          cap_valid_s = 1'b1;
        end else begin
          cap_s       = cap_r;
          cap_valid_s = cap_valid_r;
        end
        // A read that completes without any IN data is a failure.
        data_fail_s = bad | (free & read_r & ~cap_valid_r & ~recv_ready_pro);
        if (data_fail_s) begin
          if (retries_r < RETRY_MAX) begin
            retries_s = retries_r + RETRY_ONE;
            state_s   = D_ISSUE;
          end else begin
            done    = 1'b1;
            cancel  = 1'b1;
            state_s = IDLE;
          end
        end else if (free) begin
          state_s = FINISH;
        end else begin
          state_s = D_WAIT;
        end
      end

      FINISH: begin
        done = 1'b1;
        if (read_r) begin
          recv_ready = 1'b1;
          data_up_rw = cap_r;
        end else begin
          recv_ready = 1'b0;
          data_up_rw = '0;
        end
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign busy    = (state_r != IDLE);
  assign retries = retries_r;

endmodule

// File: tb/tb_usb_rw_sequencer.sv
// Self-checking bench for usb_rw_sequencer. Each request is described at
// transaction level (failures per phase, response delays, failure kinds,
// how IN data arrives); the expected issue counts, payloads, outcome,
// result data and completion cycle are derived from that plan.

module tb_usb_rw_sequencer;

  localparam int MAX = 3;

  logic        clk = 1'b0;
  logic        rst_L = 1'b0;
  logic        tran_ready = 1'b0;
  logic        read = 1'b0;
  logic [15:0] rw_addr = 16'h0;
  logic [63:0] data_down_rw = 64'h0;
  logic        free = 1'b0;
  logic        bad = 1'b0;
  logic        recv_ready_pro = 1'b0;
  logic [63:0] data_up_pro = 64'h0;
  logic        send_in;
  logic        input_ready;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [63:0] data_down_pro;
  logic [63:0] data_up_rw;
  logic        recv_ready;
  logic        done;
  logic        cancel;
  logic        busy;
  logic [1:0]  retries;

  usb_rw_sequencer dut (
    .clk(clk), .rst_L(rst_L), .tran_ready(tran_ready), .read(read),
    .rw_addr(rw_addr), .data_down_rw(data_down_rw), .free(free), .bad(bad),
    .recv_ready_pro(recv_ready_pro), .data_up_pro(data_up_pro),
    .send_in(send_in), .input_ready(input_ready), .addr(addr), .endp(endp),
    .data_down_pro(data_down_pro), .data_up_rw(data_up_rw),
    .recv_ready(recv_ready), .done(done), .cancel(cancel), .busy(busy),
    .retries(retries)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_airdy = 0, n_dirdy = 0, n_done = 0, n_cancel = 0, n_recv = 0, n_upviol = 0;
  int done_cyc = 0;

  // Request plan
  int          a_fails, d_fails;
  int          a_delay[8], d_delay[8], a_kind[8], d_kind[8];
  int          succ_mode;
  bit          poke;
  logic [63:0] good_data;

  // Free-running cycle counter.
  always @(posedge clk) cyc++;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (input_ready && endp == 4'd4) n_airdy++;
    if (input_ready && endp == 4'd8) n_dirdy++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (cancel) n_cancel++;
    if (recv_ready) n_recv++;
    if (!recv_ready && data_up_rw != 64'h0) n_upviol++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic plan_clear();
    a_fails = 0; d_fails = 0; succ_mode = 0; poke = 1'b0;
    good_data = 64'h0;
    for (int i = 0; i < 8; i++) begin
      a_delay[i] = 0; d_delay[i] = 0; a_kind[i] = 0; d_kind[i] = 0;
    end
  endtask

  task automatic plan_random(input bit rd);
    int r;
    plan_clear();
    r = $urandom_range(0, 9);
    a_fails = (r < 6) ? 0 : r - 5;
    r = $urandom_range(0, 9);
    d_fails = (r < 5) ? 0 : r - 4;
    for (int i = 0; i < 8; i++) begin
      a_delay[i] = $urandom_range(0, 2);
      d_delay[i] = $urandom_range(0, 2);
      a_kind[i]  = $urandom_range(0, 1);
      d_kind[i]  = rd ? $urandom_range(0, 2) : $urandom_range(0, 1);
    end
    succ_mode = $urandom_range(0, 2);
    poke      = ($urandom_range(0, 3) == 0);
    good_data = {$urandom, $urandom};
  endtask

  task automatic run_phase(input bit is_data, input bit rd, input logic [15:0] ad,
                           input logic [63:0] wd);
    int fails, n, dly, kind;
    bit fail, pre, cancel_now;
    logic [63:0] pay_exp;
    logic [3:0]  endp_exp;
    fails    = is_data ? d_fails : a_fails;
    n        = (fails > MAX) ? MAX + 1 : fails + 1;
    pay_exp  = is_data ? (rd ? 64'h0 : wd) : {ad, 48'h0};
    endp_exp = is_data ? 4'd8 : 4'd4;
    for (int k = 0; k < n; k++) begin
      dly  = is_data ? d_delay[k] : a_delay[k];
      kind = is_data ? d_kind[k] : a_kind[k];
      fail = (k < fails);
      pre  = 1'b0;
      chk(is_data ? "d_issue_irdy" : "a_issue_irdy", input_ready, 64'd1);
      chk("issue_endp", endp, endp_exp);
      chk("issue_send_in", send_in, is_data && rd);
      chk("issue_devaddr", addr, 64'd5);
      chk("issue_payload", data_down_pro, pay_exp);
      chk("issue_retries", retries, k);
      step();
      for (int j = 0; j < dly; j++) begin
        if (poke && j == 0) begin
          tran_ready = 1'b1; read = ~rd;
          rw_addr = 16'($urandom); data_down_rw = {$urandom, $urandom};
        end
        if (is_data && rd && !fail) begin
          if (succ_mode == 2 && j == 0) begin
            recv_ready_pro = 1'b1; data_up_pro = ~good_data;
          end
          if (succ_mode == 1 && j == dly - 1) begin
            recv_ready_pro = 1'b1; data_up_pro = good_data; pre = 1'b1;
          end
        end
        #1;
        chk("wait_irdy", input_ready, 64'd0);
        chk("wait_done", done, 64'd0);
        chk("wait_endp", endp, endp_exp);
        chk("wait_payload", data_down_pro, pay_exp);
        step();
        tran_ready = 1'b0; recv_ready_pro = 1'b0; data_up_pro = 64'h0;
      end
      if (fail) begin
        case (kind)
          0: bad = 1'b1;
          1: begin bad = 1'b1; free = 1'b1; end
          default: free = 1'b1;
        endcase
        if (is_data && kind != 2 && $urandom_range(0, 1) == 1) begin
          recv_ready_pro = 1'b1; data_up_pro = {$urandom, $urandom};
        end
      end else begin
        free = 1'b1;
        if (is_data && rd && !pre) begin
          recv_ready_pro = 1'b1; data_up_pro = good_data;
        end else if (is_data && !rd && $urandom_range(0, 1) == 1) begin
          recv_ready_pro = 1'b1; data_up_pro = {$urandom, $urandom};
        end
      end
      #1;
      cancel_now = fail && (k == MAX);
      chk("resp_done", done, cancel_now);
      chk("resp_cancel", cancel, cancel_now);
      if (cancel_now) chk("cancel_recv", recv_ready, 64'd0);
      step();
      bad = 1'b0; free = 1'b0; recv_ready_pro = 1'b0; data_up_pro = 64'h0;
    end
  endtask

  task automatic run_req(input bit rd, input logic [15:0] ad, input logic [63:0] wd);
    int n_a, n_d, cyc_exp, t0;
    int s_a, s_d, s_done, s_cancel, s_recv, s_viol;
    bit cancel_a, cancel_exp;
    cancel_a   = (a_fails > MAX);
    n_a        = cancel_a ? MAX + 1 : a_fails + 1;
    n_d        = cancel_a ? 0 : ((d_fails > MAX) ? MAX + 1 : d_fails + 1);
    cancel_exp = cancel_a || (d_fails > MAX);
    cyc_exp = cancel_exp ? 0 : 1;
    for (int i = 0; i < n_a; i++) cyc_exp += 2 + a_delay[i];
    for (int i = 0; i < n_d; i++) cyc_exp += 2 + d_delay[i];
    s_a = n_airdy; s_d = n_dirdy; s_done = n_done; s_cancel = n_cancel;
    s_recv = n_recv; s_viol = n_upviol;

    chk("idle_busy", busy, 64'd0);
    tran_ready = 1'b1; read = rd; rw_addr = ad; data_down_rw = wd;
    t0 = cyc;
    step();
    tran_ready = 1'b0; read = ~rd;
    rw_addr = 16'($urandom); data_down_rw = {$urandom, $urandom};
    chk("busy_after_accept", busy, 64'd1);
    run_phase(1'b0, rd, ad, wd);
    if (!cancel_a) run_phase(1'b1, rd, ad, wd);
    if (!cancel_exp) begin
      chk("fin_done", done, 64'd1);
      chk("fin_cancel", cancel, 64'd0);
      chk("fin_recv", recv_ready, rd);
      chk("fin_data", data_up_rw, rd ? good_data : 64'h0);
      chk("fin_busy", busy, 64'd1);
      step();
    end
    chk("end_busy", busy, 64'd0);
    chk("end_done", done, 64'd0);
    chk("latency", done_cyc - t0, cyc_exp);
    chk("n_addr_issue", n_airdy - s_a, n_a);
    chk("n_data_issue", n_dirdy - s_d, n_d);
    chk("n_done", n_done - s_done, 64'd1);
    chk("n_cancel", n_cancel - s_cancel, cancel_exp);
    chk("n_recv", n_recv - s_recv, (!cancel_exp && rd) ? 64'd1 : 64'd0);
    chk("up_zero", n_upviol - s_viol, 64'd0);
  endtask

  initial begin
    int s_done;
    // Reset state
    step();
    chk("rst_busy", busy, 64'd0);
    chk("rst_irdy", input_ready, 64'd0);
    chk("rst_done", done, 64'd0);
    chk("rst_endp", endp, 64'd0);
    chk("rst_retries", retries, 64'd0);
    #3 rst_L = 1'b1;
    step();

    // Write, no retries
    plan_clear();
    run_req(1'b0, 16'hBEEF, 64'h0123_4567_89AB_CDEF);
    // Read, IN data one cycle before free
    plan_clear();
    d_delay[0] = 1; succ_mode = 1; good_data = 64'hDEAD_BEEF_CAFE_F00D;
    run_req(1'b1, 16'h0010, 64'h0);
    // One address retry
    plan_clear();
    a_fails = 1;
    run_req(1'b0, 16'h1234, 64'hAAAA_5555_0000_FFFF);
    // Data phase exhaustion
    plan_clear();
    d_fails = 4;
    run_req(1'b0, 16'h4321, 64'h1111_2222_3333_4444);
    // bad and free together, plus tran_ready while busy
    plan_clear();
    a_fails = 1; a_kind[0] = 1; a_delay[0] = 1; d_delay[0] = 2; poke = 1'b1;
    good_data = 64'h0F0F_0F0F_F0F0_F0F0;
    run_req(1'b1, 16'h00AB, 64'h0);
    // Read completing without IN data is retried
    plan_clear();
    d_fails = 1; d_kind[0] = 2; good_data = 64'h7777_8888_9999_AAAA;
    run_req(1'b1, 16'h0F00, 64'h0);

    // Randomized requests
    for (int i = 0; i < 60; i++) begin
      bit rd;
      rd = ($urandom_range(0, 1) == 1);
      plan_random(rd);
      run_req(rd, 16'($urandom), {$urandom, $urandom});
    end

    // Reset during D_WAIT aborts silently
    s_done = n_done;
    tran_ready = 1'b1; read = 1'b0; rw_addr = 16'h5A5A; data_down_rw = 64'hFEED;
    step();
    tran_ready = 1'b0;
    step();
    free = 1'b1;
    step();
    free = 1'b0;
    step();
    chk("dwait_busy", busy, 64'd1);
    #2 rst_L = 1'b0;
    #1;
    chk("abort_busy", busy, 64'd0);
    chk("abort_endp", endp, 64'd0);
    chk("abort_addr", addr, 64'd0);
    chk("abort_payload", data_down_pro, 64'h0);
    chk("abort_retries", retries, 64'd0);
    free = 1'b1;
    step();
    step();
    free = 1'b0;
    #2 rst_L = 1'b1;
    step();
    chk("abort_no_done", n_done - s_done, 64'd0);
    plan_clear();
    run_req(1'b0, 16'hC0DE, 64'h0BAD_F00D_1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
